// File: rtl/fake_mem_2p.sv
// fake_mem_2p: simulation-only 32-bit word memory, ports A (instr) and B (data) share one array.
// Latency: stall held WAIT_CYCLES+2 cycles per access (plus 0..3 if FAKE_MEM_RANDOM_WAIT_EN is defined).
// Backpressure: x_stall high while x has a pending request; round-robin on simultaneous requests.
module fake_mem_2p #(
  parameter int ADDR_WIDTH  = 24,
  parameter int DEPTH_LOG2  = 12,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic                  a_rd,
  input  logic                  a_wr,
  input  logic [3:0]            a_byte_en,
  input  logic [31:0]           a_wdata,
  output logic [31:0]           a_rdata,
  output logic                  a_stall,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic                  b_rd,
  input  logic                  b_wr,
  input  logic [3:0]            b_byte_en,
  input  logic [31:0]           b_wdata,
  output logic [31:0]           b_rdata,
  output logic                  b_stall
);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_e;

  localparam logic GNT_A = 1'b0;
  localparam logic GNT_B = 1'b1;

  state_e                state_q;
  logic                  grant_q;
  logic                  last_grant_q;
  logic [8:0]            cnt_q;
  logic [DEPTH_LOG2-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            be_q;
  logic                  wr_q;
  logic [31:0]           a_rdata_q;
  logic [31:0]           b_rdata_q;
  logic [31:0]           mem_q [1<<DEPTH_LOG2];

  logic                  a_req;
  logic                  b_req;
  logic                  grant_d;
  logic [8:0]            cnt_d;
  logic [DEPTH_LOG2-1:0] addr_d;
  logic [31:0]           wdata_d;
  logic [3:0]            be_d;
  logic                  wr_d;
  logic                  access;

  // Upper address bits are intentionally ignored: addresses wrap onto the array.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{a_addr, b_addr};

  assign a_req  = a_rd | a_wr;
  assign b_req  = b_rd | b_wr;
  assign access = (state_q == ST_BUSY) && (cnt_q == 9'd0);

  // Arbitration: a lone requester always wins; a tie goes to the port not granted last time.
  always_comb begin
    grant_d = GNT_A;
    if (a_req && b_req) begin
      grant_d = ~last_grant_q;
    end else if (b_req) begin
      grant_d = GNT_B;
    end
  end

  // Select the winning port's request fields for latching.
  always_comb begin
    addr_d  = a_addr[DEPTH_LOG2-1:0];
    wdata_d = a_wdata;
    be_d    = a_byte_en;
    wr_d    = a_wr;
    if (grant_d == GNT_B) begin
      addr_d  = b_addr[DEPTH_LOG2-1:0];
      wdata_d = b_wdata;
      be_d    = b_byte_en;
      wr_d    = b_wr;
    end
  end

`ifdef FAKE_MEM_RANDOM_WAIT_EN
  logic [15:0] lfsr_q;

  // Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11), reproducible from reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  assign cnt_d = 9'(WAIT_CYCLES) + {7'd0, lfsr_q[1:0]};
`else
  assign cnt_d = 9'(WAIT_CYCLES);
`endif

  // Access FSM: grant in IDLE, count wait states in BUSY, report completion in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= GNT_A;
      last_grant_q <= GNT_B;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      wr_q         <= 1'b0;
      a_rdata_q    <= '0;
      b_rdata_q    <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (a_req || b_req) begin
            grant_q <= grant_d;
            if (a_req && b_req) begin
              last_grant_q <= grant_d;
            end
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (cnt_q != 9'd0) begin
            cnt_q <= cnt_q - 9'd1;
          end else begin
            if (!wr_q) begin
              if (grant_q == GNT_A) begin
                a_rdata_q <= mem_q[addr_q];
              end else begin
                b_rdata_q <= mem_q[addr_q];
              end
            end
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Byte-masked array write on the final BUSY cycle; a write cut off by reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst && access && wr_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) begin
          mem_q[addr_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  assign a_stall = ~rst & a_req & ~((state_q == ST_DONE) && (grant_q == GNT_A));
  assign b_stall = ~rst & b_req & ~((state_q == ST_DONE) && (grant_q == GNT_B));
  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;

endmodule
